conv_frame_sequencer: RTL and testbench
=======================================

# conv_frame_sequencer

Frame-level controller for the 5x5 convolution path. It reads one IX x IY input frame from the frame BRAM in raster order and streams the pixels, one per cycle, into the line buffer's pixel input. It then counts the windows returned by the line buffer until the full output map has been produced, and signals completion to the top-level Braille recognition FSM. It also provides abort, stall and drain-timeout handling.

## Interface
- I_F_BW, 8, pixel width in bits
- IX, 28, frame width in pixels
- IY, 28, frame height in pixels
- KX, 5, kernel width; sets the expected window count
- KY, 5, kernel height; sets the expected window count
- RD_LAT, 1, BRAM read latency in cycles; legal range 1..3
- DRAIN_MAX, 64, maximum cycles spent in DRAIN before a timeout error
- clk  in  1  clock; all logic is on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start-frame pulse; accepted only in IDLE
- i_abort  in  1  synchronous abort; returns to IDLE from any state
- i_stall  in  1  suppresses new BRAM reads while high
- o_mem_rd_en  out  1  BRAM read enable
- o_mem_addr  out  $clog2(IX*IY)  BRAM read address, raster order
- i_mem_rdata  in  I_F_BW  BRAM data, valid RD_LAT cycles after o_mem_rd_en
- o_pix_valid  out  1  drives the line buffer's i_in_valid
- o_pix_data  out  I_F_BW  drives the line buffer's i_in_pixel
- i_win_valid  in  1  window-valid strobe from the line buffer / convolution stage
- o_busy  out  1  high in FETCH and DRAIN
- o_done  out  1  one-cycle pulse on frame completion
- o_err  out  1  sticky timeout flag; cleared when the next start is accepted
- o_win_cnt  out  $clog2(NWIN+1)  number of windows received in the current frame

## Operation
- NWIN = (IX-KX+1)*(IY-KY+1), which is 576 at the defaults. NPIX = IX*IY, which is 784.
- States are IDLE, FETCH, DRAIN and DONE.
- **IDLE.** An i_start here clears o_win_cnt, the drain counter and o_err, sets o_mem_addr to 0 and moves to FETCH. In any other state i_start is ignored.
- **FETCH.**
  - Each cycle with i_stall=0 issues one read: o_mem_rd_en=1 at the current address, and the address then increments.
  - A cycle with i_stall=1 issues no read and holds the address. Reads already in flight still complete.
  - The cycle that issues the read of address NPIX-1 is followed by a move to DRAIN.
- **Pixel output.** o_pix_valid is o_mem_rd_en delayed by RD_LAT cycles. o_pix_data is i_mem_rdata, passed through unregistered and qualified by o_pix_valid. In-flight pixels still emerge after the move to DRAIN or DONE.
- **Window counting.** o_win_cnt increments on every i_win_valid seen in FETCH or DRAIN, saturating at NWIN. i_win_valid is ignored in IDLE and DONE.
- **Completion.**
  - If a cycle's increment makes o_win_cnt equal NWIN, the next state is DONE. This applies in either FETCH or DRAIN.
  - When completion occurs in FETCH, any remaining reads are not issued.
- **DRAIN.**
  - The drain counter increments every cycle.
  - If it reaches DRAIN_MAX-1 with o_win_cnt < NWIN, the next state is DONE and o_err is set.
  - If a window completes the count on that same cycle, completion wins and o_err stays 0.
- **DONE.** o_done=1 for exactly one cycle, then the state returns to IDLE.
- **Abort.**
  - i_abort has priority over every other transition. The next state is IDLE, with no o_done and o_err unchanged.
  - Reads already issued still produce o_pix_valid.
  - o_win_cnt holds its value until the next accepted start.
- **Simultaneous i_start and i_abort in IDLE.** Abort wins and the start is dropped.

## Timing
- Reset values: state IDLE. o_mem_rd_en, o_pix_valid, o_busy, o_done and o_err are 0. o_mem_addr, o_pix_data and o_win_cnt are 0.
- Start accepted at cycle T: the first read is at T+1 and the first o_pix_valid is at T+1+RD_LAT.
- Unstalled frame: reads occupy cycles T+1 through T+NPIX, and DRAIN begins at T+NPIX+1.
- Each stall cycle delays all subsequent reads and the DRAIN entry by one cycle.
- o_done is asserted one cycle after the i_win_valid that completes the count; o_busy falls in that same DONE cycle.
- The minimum gap from o_done to the next accepted start is 1 cycle.

## Structure
- Package conv_seq_pkg holds:
  - the state enum {IDLE, FETCH, DRAIN, DONE};
  - the NWIN/NPIX computation, as localparams derived from IX, IY, KX and KY.
- Sub-module rd_lat_pipe is an RD_LAT-deep valid shift register with asynchronous reset, producing o_pix_valid.
- The line buffer is instantiated beside this block at the top level; this block does not contain it.

## Test plan
- **Nominal frame:** defaults, BRAM holds addr&0xFF, line buffer model returns 576 windows. Expect 784 pixels with data 0,1,…,255,0,… in order, then o_done pulsed once, o_win_cnt=576, o_err=0.
- **Stall:** hold i_stall for 10 cycles at address 100. Expect no reads during the stall, an addr sequence with no gaps or repeats, DRAIN entry delayed by exactly 10 cycles, and pixel count still 784.
- **Timeout:** model returns only 570 windows. Expect DONE exactly DRAIN_MAX cycles after DRAIN entry, o_err=1 and o_win_cnt=570. The next i_start clears o_err.
- **Abort mid-FETCH:** i_abort at address 300. Expect IDLE next cycle, no o_done, exactly RD_LAT trailing o_pix_valid pulses. A following start reads from address 0.
- **Start while busy and start/abort collision:** i_start during FETCH is ignored, with no address reset. i_start and i_abort together in IDLE leave the state in IDLE.
- **Reset mid-frame:** reset_n low at address 500. All outputs return to 0 asynchronously. After release the block stays in IDLE until i_start.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state type and frame geometry helpers for conv_frame_sequencer
package conv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Default frame / kernel geometry of the Braille convolution path.
    localparam int DEF_IX = 28;
    localparam int DEF_IY = 28;
    localparam int DEF_KX = 5;
    localparam int DEF_KY = 5;

    // Pixels per input frame.
    function automatic int calc_npix(input int ix, input int iy);
        return ix * iy;
    endfunction

    // Valid (no padding) window positions of a kx*ky kernel over an ix*iy frame.
    function automatic int calc_nwin(input int ix, input int iy, input int kx, input int ky);
        return (ix - kx + 1) * (iy - ky + 1);
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - DEPTH-stage valid shift register matching the BRAM read latency
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   i_valid        read enable issued this cycle
//   o_valid        i_valid delayed by DEPTH cycles
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign o_valid = stage[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame fetch and window-count controller for the 5x5 conv path
// Ports:
//   clk, reset_n    clock / asynchronous active-low reset
//   i_start         start a frame (taken only when idle)
//   i_abort         return to idle from any state; highest priority
//   i_stall         hold off new BRAM reads
//   o_mem_rd_en     BRAM read enable
//   o_mem_addr      BRAM read address, raster order
//   i_mem_rdata     BRAM data, RD_LAT cycles after the read
//   o_pix_valid     pixel strobe into the line buffer
//   o_pix_data      pixel into the line buffer (zero when not valid)
//   i_win_valid     window strobe back from the line buffer / conv stage
//   o_busy          high while fetching or draining
//   o_done          one-cycle frame-complete pulse
//   o_err           sticky drain timeout flag
//   o_win_cnt       windows received in the current frame
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int I_F_BW    = 8,
    parameter int IX        = DEF_IX,
    parameter int IY        = DEF_IY,
    parameter int KX        = DEF_KX,
    parameter int KY        = DEF_KY,
    parameter int RD_LAT    = 1,
    parameter int DRAIN_MAX = 64
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          i_start,
    input  logic                                          i_abort,
    input  logic                                          i_stall,
    output logic                                          o_mem_rd_en,
    output logic [$clog2(calc_npix(IX, IY))-1:0]          o_mem_addr,
    input  logic [I_F_BW-1:0]                             i_mem_rdata,
    output logic                                          o_pix_valid,
    output logic [I_F_BW-1:0]                             o_pix_data,
    input  logic                                          i_win_valid,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic                                          o_err,
    output logic [$clog2(calc_nwin(IX, IY, KX, KY)+1)-1:0] o_win_cnt
);

    localparam int NPIX = calc_npix(IX, IY);
    localparam int NWIN = calc_nwin(IX, IY, KX, KY);
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(NWIN + 1);
    localparam int DW   = $clog2(DRAIN_MAX + 1);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(NPIX - 1);
    localparam logic [CW-1:0] WIN_FULL   = CW'(NWIN);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    seq_state_t    state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [CW-1:0] win_cnt, win_cnt_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          err, err_nxt;
    logic          rd_en;
    logic          win_hit;
    logic          pix_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            win_cnt   <= '0;
            drain_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            win_cnt   <= win_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        win_cnt_nxt   = win_cnt;
        drain_cnt_nxt = drain_cnt;
        err_nxt       = err;
        rd_en         = 1'b0;
        win_hit       = 1'b0;

        // Windows only count while a frame is in flight; the counter saturates.
        if ((state == FETCH || state == DRAIN) && i_win_valid && win_cnt != WIN_FULL) begin
            win_cnt_nxt = win_cnt + CW'(1);
            win_hit     = (win_cnt == WIN_FULL - CW'(1));
        end

        case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_nxt     = FETCH;
                    addr_nxt      = '0;
                    win_cnt_nxt   = '0;
                    drain_cnt_nxt = '0;
                    err_nxt       = 1'b0;
                end
            end
            FETCH: begin
                if (!i_stall) begin
                    rd_en = 1'b1;
                    if (addr == LAST_ADDR) begin
                        state_nxt = DRAIN;
                    end else begin
                        addr_nxt = addr + AW'(1);
                    end
                end
                // A full window count ends the frame even if pixels remain unread.
                if (win_hit) begin
                    state_nxt = DONE;
                end
            end
            DRAIN: begin
                drain_cnt_nxt = drain_cnt + DW'(1);
                if (win_hit) begin
                    state_nxt = DONE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides any transition, including a timeout, and keeps the error flag as is.
        if (i_abort) begin
            state_nxt = IDLE;
            err_nxt   = err;
        end
    end

    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (rd_en),
        .o_valid (pix_valid)
    );

    assign o_mem_rd_en = rd_en;
    assign o_mem_addr  = addr;
    assign o_pix_valid = pix_valid;
    assign o_pix_data  = pix_valid ? i_mem_rdata : '0;
    assign o_busy      = (state == FETCH) || (state == DRAIN);
    assign o_done      = (state == DONE);
    assign o_err       = err;
    assign o_win_cnt   = win_cnt;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - randomized self-checking bench for conv_frame_sequencer
`timescale 1ns/1ps
module tb_conv_frame_sequencer;

    localparam int I_F_BW    = 8;
    localparam int IX        = 28;
    localparam int IY        = 28;
    localparam int KX        = 5;
    localparam int KY        = 5;
    localparam int RD_LAT    = 1;
    localparam int DRAIN_MAX = 64;
    localparam int NPIX      = IX * IY;
    localparam int NWIN      = (IX - KX + 1) * (IY - KY + 1);
    localparam int AW        = $clog2(NPIX);
    localparam int CW        = $clog2(NWIN + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_abort = 1'b0;
    logic              i_stall = 1'b0;
    logic              o_mem_rd_en;
    logic [AW-1:0]     o_mem_addr;
    logic [I_F_BW-1:0] i_mem_rdata = '0;
    logic              o_pix_valid;
    logic [I_F_BW-1:0] o_pix_data;
    logic              i_win_valid = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [CW-1:0]     o_win_cnt;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .I_F_BW (I_F_BW), .IX (IX), .IY (IY), .KX (KX), .KY (KY),
        .RD_LAT (RD_LAT), .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .clk (clk), .reset_n (reset_n), .i_start (i_start), .i_abort (i_abort),
        .i_stall (i_stall), .o_mem_rd_en (o_mem_rd_en), .o_mem_addr (o_mem_addr),
        .i_mem_rdata (i_mem_rdata), .o_pix_valid (o_pix_valid), .o_pix_data (o_pix_data),
        .i_win_valid (i_win_valid), .o_busy (o_busy), .o_done (o_done), .o_err (o_err),
        .o_win_cnt (o_win_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 64;

    int rd_addr_q[$];
    int rd_cyc_q[$];
    int pix_q[$];
    int pix_cyc_q[$];
    int done_cyc_q[$];
    bit lat_v[64];
    int lat_addr[64];
    bit sched[64];
    int win_delay, win_budget, win_sched, win_seen, last_win_cyc;
    bit frame_active = 1'b0;
    int stall_at = -1, stall_len = 0, stall_rem = 0, stall_prob = 0, stall_cnt, rd_in_stall;
    int abort_at = -1, abort_cyc = -10, start_at = -1;
    int pix_qual_err;
    int err_at_done, cnt_at_done, busy_at_done, busy_after_abort;
    int start_cyc;
    int seq_err, data_err;

    // One clock cycle: BRAM and line-buffer models drive inputs, outputs are sampled mid-cycle.
    task automatic cycle();
        int c, p;
        c = cyc % 64;
        p = (cyc - RD_LAT) % 64;
        i_mem_rdata = lat_v[p] ? I_F_BW'(lat_addr[p] & 'hFF) : I_F_BW'($urandom);
        i_win_valid = sched[c];
        sched[c] = 1'b0;
        if (stall_rem == 0 && stall_at >= 0 && rd_addr_q.size() == stall_at) begin
            stall_rem = stall_len;
            stall_at = -1;
        end
        if (stall_rem > 0) begin
            i_stall = 1'b1;
            stall_rem--;
        end else begin
            i_stall = (stall_prob > 0) && ($urandom_range(0, 99) < stall_prob);
        end
        if (abort_at >= 0 && rd_addr_q.size() == abort_at) begin
            i_abort = 1'b1;
            abort_cyc = cyc;
            abort_at = -1;
        end
        if (start_at >= 0 && rd_addr_q.size() == start_at) begin
            i_start = 1'b1;
            start_at = -1;
        end
        #1;
        if (o_done) begin
            done_cyc_q.push_back(cyc);
            frame_active = 1'b0;
            err_at_done = int'(o_err);
            cnt_at_done = int'(o_win_cnt);
            busy_at_done = int'(o_busy);
        end
        if (frame_active && i_stall && rd_addr_q.size() < NPIX) stall_cnt++;
        if (i_stall && o_mem_rd_en) rd_in_stall++;
        if (frame_active && i_win_valid) begin
            win_seen++;
            last_win_cyc = cyc;
        end
        if (cyc == abort_cyc + 1) busy_after_abort = int'(o_busy);
        if (o_mem_rd_en) begin
            rd_addr_q.push_back(int'(o_mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        lat_v[c] = o_mem_rd_en;
        lat_addr[c] = int'(o_mem_addr);
        if (o_pix_valid) begin
            pix_q.push_back(int'(o_pix_data));
            pix_cyc_q.push_back(cyc);
            // Line buffer: one window per pixel once the first window's pixels have arrived.
            if (pix_q.size() > NPIX - NWIN && win_sched < win_budget) begin
                sched[(cyc + win_delay) % 64] = 1'b1;
                win_sched++;
            end
        end else if (o_pix_data !== '0) begin
            pix_qual_err++;
        end
        if (i_abort) frame_active = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        i_start = 1'b0;
        i_abort = 1'b0;
    endtask

    task automatic start_frame(input int budget);
        rd_addr_q.delete(); rd_cyc_q.delete(); pix_q.delete(); pix_cyc_q.delete(); done_cyc_q.delete();
        for (int i = 0; i < 64; i++) sched[i] = 1'b0;
        win_budget = budget; win_delay = $urandom_range(1, 10); win_sched = 0; win_seen = 0;
        last_win_cyc = -1; stall_cnt = 0; rd_in_stall = 0; pix_qual_err = 0;
        stall_at = -1; stall_rem = 0; stall_prob = 0; abort_at = -1; start_at = -1;
        abort_cyc = -10; busy_after_abort = -1; err_at_done = -1; cnt_at_done = -1; busy_at_done = -1;
        start_cyc = cyc;
        i_start = 1'b1;
        cycle();
        frame_active = 1'b1;
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound && done_cyc_q.size() == 0; k++) cycle();
    endtask

    task automatic analyse_frame();
        seq_err = 0;
        data_err = 0;
        foreach (rd_addr_q[k]) if (rd_addr_q[k] != k) seq_err++;
        foreach (pix_q[k]) if (pix_q[k] != (k & 'hFF)) data_err++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({o_mem_rd_en, o_pix_valid, o_busy, o_done, o_err} !== 5'b0) begin n_bad++;
            $display("FAIL reset_flags: got %b expected 00000", {o_mem_rd_en, o_pix_valid, o_busy, o_done, o_err}); end
        n_cmp++; if (o_mem_addr !== '0 || o_pix_data !== '0 || o_win_cnt !== '0) begin n_bad++;
            $display("FAIL reset_values: addr %0d data %0d cnt %0d expected 0", o_mem_addr, o_pix_data, o_win_cnt); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) cycle();
        n_cmp++; if (rd_addr_q.size() != 0 || o_busy !== 1'b0) begin n_bad++;
            $display("FAIL reset_idle: reads %0d busy %0d expected 0 0", rd_addr_q.size(), o_busy); end
    endtask

    task automatic test_nominal();
        start_frame(NWIN);
        wait_done(3000);
        repeat (3) cycle();
        analyse_frame();
        n_cmp++; if (rd_addr_q.size() != NPIX || seq_err != 0) begin n_bad++;
            $display("FAIL nominal_reads: count %0d seq_err %0d expected %0d 0", rd_addr_q.size(), seq_err, NPIX); end
        n_cmp++; if (rd_cyc_q[0] != start_cyc + 1) begin n_bad++;
            $display("FAIL nominal_first_read: got %0d expected %0d", rd_cyc_q[0], start_cyc + 1); end
        n_cmp++; if (rd_cyc_q[$] != start_cyc + NPIX) begin n_bad++;
            $display("FAIL nominal_last_read: got %0d expected %0d", rd_cyc_q[$], start_cyc + NPIX); end
        n_cmp++; if (pix_cyc_q[0] != start_cyc + 1 + RD_LAT) begin n_bad++;
            $display("FAIL nominal_first_pix: got %0d expected %0d", pix_cyc_q[0], start_cyc + 1 + RD_LAT); end
        n_cmp++; if (pix_q.size() != NPIX || data_err != 0 || pix_qual_err != 0) begin n_bad++;
            $display("FAIL nominal_pixels: count %0d data_err %0d qual_err %0d expected %0d 0 0", pix_q.size(), data_err, pix_qual_err, NPIX); end
        n_cmp++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != last_win_cyc + 1) begin n_bad++;
            $display("FAIL nominal_done: pulses %0d at %0d expected 1 at %0d", done_cyc_q.size(), done_cyc_q[0], last_win_cyc + 1); end
        n_cmp++; if (cnt_at_done != NWIN || err_at_done != 0 || busy_at_done != 0) begin n_bad++;
            $display("FAIL nominal_status: cnt %0d err %0d busy %0d expected %0d 0 0", cnt_at_done, err_at_done, busy_at_done, NWIN); end
    endtask

    task automatic test_stall();
        int r100;
        start_frame(NWIN);
        stall_at = 100;
        stall_len = 10;
        wait_done(3000);
        analyse_frame();
        r100 = (rd_cyc_q.size() > 100) ? rd_cyc_q[100] : -1;
        n_cmp++; if (rd_in_stall != 0) begin n_bad++;
            $display("FAIL stall_no_reads: got %0d reads while stalled expected 0", rd_in_stall); end
        n_cmp++; if (r100 != start_cyc + 101 + 10) begin n_bad++;
            $display("FAIL stall_resume: read 100 at %0d expected %0d", r100, start_cyc + 111); end
        n_cmp++; if (rd_addr_q.size() != NPIX || seq_err != 0 || rd_cyc_q[$] != start_cyc + NPIX + 10) begin n_bad++;
            $display("FAIL stall_reads: count %0d seq_err %0d last %0d expected %0d 0 %0d", rd_addr_q.size(), seq_err, rd_cyc_q[$], NPIX, start_cyc + NPIX + 10); end
        n_cmp++; if (pix_q.size() != NPIX || done_cyc_q.size() != 1 || cnt_at_done != NWIN) begin n_bad++;
            $display("FAIL stall_frame: pix %0d done %0d cnt %0d expected %0d 1 %0d", pix_q.size(), done_cyc_q.size(), cnt_at_done, NPIX, NWIN); end
    endtask

    task automatic test_timeout();
        start_frame(NWIN - 6);
        wait_done(3000);
        n_cmp++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + NPIX + 1 + DRAIN_MAX) begin n_bad++;
            $display("FAIL timeout_done: pulses %0d at %0d expected 1 at %0d", done_cyc_q.size(), done_cyc_q[0], start_cyc + NPIX + 1 + DRAIN_MAX); end
        n_cmp++; if (err_at_done != 1 || cnt_at_done != NWIN - 6) begin n_bad++;
            $display("FAIL timeout_status: err %0d cnt %0d expected 1 %0d", err_at_done, cnt_at_done, NWIN - 6); end
        n_cmp++; if (o_err !== 1'b1) begin n_bad++;
            $display("FAIL timeout_sticky: err %0d expected 1", o_err); end
        start_frame(NWIN);
        n_cmp++; if (o_err !== 1'b0 || o_win_cnt !== '0) begin n_bad++;
            $display("FAIL timeout_clear: err %0d cnt %0d expected 0 0", o_err, o_win_cnt); end
        i_abort = 1'b1;
        cycle();
        repeat (4) cycle();
    endtask

    task automatic test_abort();
        start_frame(NWIN);
        abort_at = 300;
        for (int k = 0; k < 2000 && abort_cyc < 0; k++) cycle();
        repeat (8) cycle();
        n_cmp++; if (busy_after_abort != 0 || done_cyc_q.size() != 0) begin n_bad++;
            $display("FAIL abort_idle: busy %0d done %0d expected 0 0", busy_after_abort, done_cyc_q.size()); end
        begin
            int trail;
            trail = 0;
            foreach (pix_cyc_q[k]) if (pix_cyc_q[k] > abort_cyc) trail++;
            n_cmp++; if (trail != RD_LAT || rd_addr_q.size() != 301 || pix_q.size() != 301) begin n_bad++;
                $display("FAIL abort_trail: trail %0d reads %0d pix %0d expected %0d 301 301", trail, rd_addr_q.size(), pix_q.size(), RD_LAT); end
        end
        n_cmp++; if (int'(o_win_cnt) != win_seen) begin n_bad++;
            $display("FAIL abort_cnt_hold: got %0d expected %0d", o_win_cnt, win_seen); end
        start_frame(NWIN);
        repeat (3) cycle();
        n_cmp++; if (rd_addr_q[0] != 0 || rd_cyc_q[0] != start_cyc + 1) begin n_bad++;
            $display("FAIL abort_restart: addr %0d at %0d expected 0 at %0d", rd_addr_q[0], rd_cyc_q[0], start_cyc + 1); end
    endtask

    task automatic test_start_collision();
        start_at = 60;
        wait_done(3000);
        repeat (3) cycle();
        analyse_frame();
        n_cmp++; if (rd_addr_q.size() != NPIX || seq_err != 0 || done_cyc_q.size() != 1) begin n_bad++;
            $display("FAIL start_busy: reads %0d seq_err %0d done %0d expected %0d 0 1", rd_addr_q.size(), seq_err, done_cyc_q.size(), NPIX); end
        i_start = 1'b1;
        i_abort = 1'b1;
        cycle();
        repeat (4) cycle();
        n_cmp++; if (rd_addr_q.size() != NPIX || o_busy !== 1'b0 || o_win_cnt !== CW'(NWIN)) begin n_bad++;
            $display("FAIL collision: reads %0d busy %0d cnt %0d expected %0d 0 %0d", rd_addr_q.size(), o_busy, o_win_cnt, NPIX, NWIN); end
    endtask

    task automatic test_reset_mid();
        start_frame(NWIN);
        for (int k = 0; k < 2000 && rd_addr_q.size() < 500; k++) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({o_mem_rd_en, o_pix_valid, o_busy, o_done, o_err} !== 5'b0 || o_mem_addr !== '0 || o_pix_data !== '0 || o_win_cnt !== '0) begin n_bad++;
            $display("FAIL reset_mid_async: flags %b addr %0d data %0d cnt %0d expected all 0",
                     {o_mem_rd_en, o_pix_valid, o_busy, o_done, o_err}, o_mem_addr, o_pix_data, o_win_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin lat_v[i] = 1'b0; sched[i] = 1'b0; end
        rd_addr_q.delete(); pix_q.delete();
        frame_active = 1'b0;
        repeat (6) cycle();
        n_cmp++; if (rd_addr_q.size() != 0 || pix_q.size() != 0 || o_busy !== 1'b0) begin n_bad++;
            $display("FAIL reset_mid_idle: reads %0d pix %0d busy %0d expected 0 0 0", rd_addr_q.size(), pix_q.size(), o_busy); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            start_frame(NWIN);
            stall_prob = $urandom_range(5, 25);
            wait_done(4000);
            stall_prob = 0;
            analyse_frame();
            n_cmp++; if (rd_addr_q.size() != NPIX || seq_err != 0 || rd_in_stall != 0) begin n_bad++;
                $display("FAIL b2b_reads[%0d]: count %0d seq_err %0d stalled_reads %0d expected %0d 0 0", f, rd_addr_q.size(), seq_err, rd_in_stall, NPIX); end
            n_cmp++; if (rd_cyc_q[$] != start_cyc + NPIX + stall_cnt) begin n_bad++;
                $display("FAIL b2b_last_read[%0d]: got %0d expected %0d", f, rd_cyc_q[$], start_cyc + NPIX + stall_cnt); end
            n_cmp++; if (pix_q.size() != NPIX || data_err != 0 || pix_qual_err != 0) begin n_bad++;
                $display("FAIL b2b_pixels[%0d]: count %0d data_err %0d qual_err %0d expected %0d 0 0", f, pix_q.size(), data_err, pix_qual_err, NPIX); end
            n_cmp++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != last_win_cyc + 1 || cnt_at_done != NWIN || err_at_done != 0) begin n_bad++;
                $display("FAIL b2b_done[%0d]: pulses %0d at %0d cnt %0d err %0d expected 1 at %0d %0d 0",
                         f, done_cyc_q.size(), done_cyc_q[0], cnt_at_done, err_at_done, last_win_cyc + 1, NWIN); end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_timeout();
        test_abort();
        test_start_collision();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
